// File: rtl/rvvi_frame_pkg.sv
// Shared definitions for the RVVI host link: ack frame word layout, ethertype and parser states.
package rvvi_frame_pkg;

    localparam int unsigned RVVI_W_TYPE     = 3;
    localparam int unsigned RVVI_W_FCNT     = 4;
    localparam int unsigned RVVI_W_MINSTRET = 6;
    localparam int unsigned RVVI_W_LOAD     = 8;

    localparam logic [15:0] RVVI_ETH_TYPE = 16'h005c;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StCheck,
        StDiscard
    } AckStateType;

    // Saturating add of a (possibly huge) 64-bit increment onto a 16-bit counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [63:0] b);
        logic [63:0] room;
        room = 64'(16'hFFFF - a);
        if (b > room) begin
            return 16'hFFFF;
        end
        return a + b[15:0];
    endfunction

endpackage

// File: rtl/rvvi_ack_parser.sv
// Walks the 9-word ack frame off the MAC RX stream and presents the captured fields for one
// cycle (CHECK state); framing errors are reported combinationally on the offending beat.
module rvvi_ack_parser
    import rvvi_frame_pkg::*;
#(
    parameter logic [15:0] EthType = RVVI_ETH_TYPE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] rx_data_i,
    input  logic [3:0]  rx_keep_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    output logic        frame_valid_o,
    output logic        frame_err_o,
    output logic [63:0] frame_cnt_o,
    output logic [63:0] frame_minstret_o,
    output logic [31:0] frame_load_o
);

    AckStateType state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic [63:0] fcnt_q, fcnt_d;
    logic [63:0] minstret_q, minstret_d;
    logic [31:0] load_q, load_d;

    logic at_type, at_load, keep_full;

    assign at_type   = (beat_q == 4'(RVVI_W_TYPE));
    assign at_load   = (beat_q == 4'(RVVI_W_LOAD));
    assign keep_full = (rx_keep_i == 4'hF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_valid_i) begin
                    state_d = rx_last_i ? StIdle : StHdr;
                end
            end
            StHdr: begin
                if (rx_valid_i) begin
                    if (rx_last_i) begin
                        state_d = StIdle;
                    end else if (at_type) begin
                        state_d = (rx_data_i[15:0] == EthType) ? StBody : StDiscard;
                    end
                end
            end
            StBody: begin
                if (rx_valid_i) begin
                    if (at_load) begin
                        if (!rx_last_i) begin
                            state_d = StDiscard;
                        end else begin
                            state_d = keep_full ? StCheck : StIdle;
                        end
                    end else if (rx_last_i) begin
                        state_d = StIdle;
                    end
                end
            end
            StCheck: state_d = StIdle;
            StDiscard: begin
                if (rx_valid_i && rx_last_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Any frame end other than a well-formed word 8 is a framing error.
    always_comb begin
        frame_valid_o = (state_q == StCheck);
        frame_err_o   = 1'b0;
        if (rx_valid_i && rx_last_i) begin
            unique case (state_q)
                StIdle, StHdr, StDiscard: frame_err_o = 1'b1;
                StBody:                   frame_err_o = !(at_load && keep_full);
                default:                  frame_err_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        beat_d     = beat_q;
        fcnt_d     = fcnt_q;
        minstret_d = minstret_q;
        load_d     = load_q;
        if (state_d == StIdle) begin
            beat_d = 4'd0;
        end else if (rx_valid_i) begin
            beat_d = beat_q + 4'd1;
        end
        if (rx_valid_i && state_q == StBody) begin
            case (beat_q)
                4'(RVVI_W_FCNT):         fcnt_d[31:0]      = rx_data_i;
                4'(RVVI_W_FCNT + 1):     fcnt_d[63:32]     = rx_data_i;
                4'(RVVI_W_MINSTRET):     minstret_d[31:0]  = rx_data_i;
                4'(RVVI_W_MINSTRET + 1): minstret_d[63:32] = rx_data_i;
                4'(RVVI_W_LOAD):         load_d            = rx_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q     <= 4'd0;
            fcnt_q     <= 64'd0;
            minstret_q <= 64'd0;
            load_q     <= 32'd0;
        end else begin
            beat_q     <= beat_d;
            fcnt_q     <= fcnt_d;
            minstret_q <= minstret_d;
            load_q     <= load_d;
        end
    end

    assign frame_cnt_o      = fcnt_q;
    assign frame_minstret_o = minstret_q;
    assign frame_load_o     = load_q;

endmodule

// File: rtl/rvvi_ack_monitor.sv
// RVVI host-link receive side: validates host acks against the sent-frame count, accounts for
// lost frames (skipped acks or timeout) and throttles the core when the host falls behind.
module rvvi_ack_monitor
    import rvvi_frame_pkg::*;
#(
    parameter logic [15:0] ETH_TYPE        = RVVI_ETH_TYPE,
    parameter logic [31:0] MAX_OUTSTANDING = 32'd8,
    parameter logic [31:0] LOAD_THRESHOLD  = 32'hC000_0000,
    parameter logic [31:0] ACK_TIMEOUT     = 32'd100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] RxData,
    input  logic [3:0]  RxKeep,
    input  logic        RxValid,
    input  logic        RxLast,
    output logic        RxReady,
    input  logic        FrameSent,
    output logic        ExternalStall,
    output logic        AckValid,
    output logic [63:0] AckFrameCount,
    output logic [63:0] AckMinstret,
    output logic [31:0] HostLoad,
    output logic [15:0] DropCount,
    output logic        BadFrame,
    output logic        Timeout
);

    logic        frame_valid, frame_err;
    logic [63:0] frame_cnt, frame_minstret;
    logic [31:0] frame_load;

    rvvi_ack_parser #(
        .EthType(ETH_TYPE)
    ) u_parser (
        .clk_i           (clk),
        .rst_ni          (reset_n),
        .rx_data_i       (RxData),
        .rx_keep_i       (RxKeep),
        .rx_valid_i      (RxValid),
        .rx_last_i       (RxLast),
        .frame_valid_o   (frame_valid),
        .frame_err_o     (frame_err),
        .frame_cnt_o     (frame_cnt),
        .frame_minstret_o(frame_minstret),
        .frame_load_o    (frame_load)
    );

    logic [63:0] tx_sent_q, tx_sent_d;
    logic [63:0] next_exp_q, next_exp_d;
    logic [63:0] outstanding;
    logic [31:0] tcnt_q, tcnt_d;
    logic [63:0] ack_fcnt_q, ack_fcnt_d;
    logic [63:0] ack_minstret_q, ack_minstret_d;
    logic [31:0] host_load_q, host_load_d;
    logic [15:0] drop_q, drop_d;
    logic        ack_valid_q, ack_valid_d;
    logic        bad_q, bad_d;
    logic        timeout_q, timeout_d;
    logic        stall_q, stall_d;
    logic        rx_ready_q;
    logic        good_ack, timeout_hit;

    // Comparisons use the pre-increment TxSent even when FrameSent lands in the same cycle.
    assign outstanding = tx_sent_q - next_exp_q;
    assign good_ack    = frame_valid && (frame_cnt >= next_exp_q) && (frame_cnt < tx_sent_q);
    assign timeout_hit = (outstanding != 64'd0) && (tcnt_q == ACK_TIMEOUT - 32'd1) && !good_ack;

    always_comb begin
        tx_sent_d      = tx_sent_q + 64'(FrameSent);
        next_exp_d     = next_exp_q;
        tcnt_d         = tcnt_q;
        ack_fcnt_d     = ack_fcnt_q;
        ack_minstret_d = ack_minstret_q;
        host_load_d    = host_load_q;
        drop_d         = drop_q;
        ack_valid_d    = 1'b0;
        timeout_d      = 1'b0;
        bad_d          = frame_err || (frame_valid && !good_ack);
        if (good_ack) begin
            drop_d         = sat_add16(drop_q, frame_cnt - next_exp_q);
            next_exp_d     = frame_cnt + 64'd1;
            ack_fcnt_d     = frame_cnt;
            ack_minstret_d = frame_minstret;
            host_load_d    = frame_load;
            ack_valid_d    = 1'b1;
            tcnt_d         = 32'd0;
        end else if (timeout_hit) begin
            drop_d      = sat_add16(drop_q, outstanding);
            next_exp_d  = tx_sent_q;
            host_load_d = 32'd0;
            timeout_d   = 1'b1;
            tcnt_d      = 32'd0;
        end else if (outstanding == 64'd0) begin
            tcnt_d = 32'd0;
        end else begin
            tcnt_d = tcnt_q + 32'd1;
        end
        stall_d = (outstanding >= 64'(MAX_OUTSTANDING)) || (host_load_q >= LOAD_THRESHOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sent_q      <= 64'd0;
            next_exp_q     <= 64'd0;
            tcnt_q         <= 32'd0;
            ack_fcnt_q     <= 64'd0;
            ack_minstret_q <= 64'd0;
            host_load_q    <= 32'd0;
            drop_q         <= 16'd0;
            ack_valid_q    <= 1'b0;
            bad_q          <= 1'b0;
            timeout_q      <= 1'b0;
            stall_q        <= 1'b0;
            rx_ready_q     <= 1'b0;
        end else begin
            tx_sent_q      <= tx_sent_d;
            next_exp_q     <= next_exp_d;
            tcnt_q         <= tcnt_d;
            ack_fcnt_q     <= ack_fcnt_d;
            ack_minstret_q <= ack_minstret_d;
            host_load_q    <= host_load_d;
            drop_q         <= drop_d;
            ack_valid_q    <= ack_valid_d;
            bad_q          <= bad_d;
            timeout_q      <= timeout_d;
            stall_q        <= stall_d;
            rx_ready_q     <= 1'b1;
        end
    end

    assign RxReady       = rx_ready_q;
    assign ExternalStall = stall_q;
    assign AckValid      = ack_valid_q;
    assign AckFrameCount = ack_fcnt_q;
    assign AckMinstret   = ack_minstret_q;
    assign HostLoad      = host_load_q;
    assign DropCount     = drop_q;
    assign BadFrame      = bad_q;
    assign Timeout       = timeout_q;

endmodule

// File: tb/tb_rvvi_ack_monitor.sv
// Directed bench for rvvi_ack_monitor: good acks, stall sources, malformed frames, timeout,
// same-cycle FrameSent/CHECK and mid-frame reset.
module tb_rvvi_ack_monitor;
    import rvvi_frame_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] RxData;
    logic [3:0]  RxKeep;
    logic        RxValid;
    logic        RxLast;
    logic        RxReady;
    logic        FrameSent;
    logic        ExternalStall;
    logic        AckValid;
    logic [63:0] AckFrameCount;
    logic [63:0] AckMinstret;
    logic [31:0] HostLoad;
    logic [15:0] DropCount;
    logic        BadFrame;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    rvvi_ack_monitor #(
        .ETH_TYPE       (16'h005c),
        .MAX_OUTSTANDING(32'd8),
        .LOAD_THRESHOLD (32'hC000_0000),
        .ACK_TIMEOUT    (32'd50)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .RxData       (RxData),
        .RxKeep       (RxKeep),
        .RxValid      (RxValid),
        .RxLast       (RxLast),
        .RxReady      (RxReady),
        .FrameSent    (FrameSent),
        .ExternalStall(ExternalStall),
        .AckValid     (AckValid),
        .AckFrameCount(AckFrameCount),
        .AckMinstret  (AckMinstret),
        .HostLoad     (HostLoad),
        .DropCount    (DropCount),
        .BadFrame     (BadFrame),
        .Timeout      (Timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Minstret word pair carries {32'h1, c[31:0]} so both halves are exercised.
    task automatic send_frame(input logic [63:0] c, input logic [31:0] load,
                              input logic [15:0] etype, input int last_at);
        for (int i = 0; i <= last_at; i++) begin
            case (i)
                0, 1, 2: RxData = 32'hA5A5_0000 + 32'(i);
                3:       RxData = {16'h1234, etype};
                4:       RxData = c[31:0];
                5:       RxData = c[63:32];
                6:       RxData = c[31:0];
                7:       RxData = 32'h0000_0001;
                8:       RxData = load;
                default: RxData = 32'hDEAD_BEEF;
            endcase
            RxValid = 1'b1;
            RxLast  = (i == last_at);
            tick();
        end
        RxValid = 1'b0;
        RxLast  = 1'b0;
        RxData  = 32'd0;
    endtask

    task automatic send_good(input logic [63:0] c, input logic [31:0] load,
                             input logic [15:0] exp_drop);
        send_frame(c, load, RVVI_ETH_TYPE, 8);
        tick();
        chk("ack_valid", 64'(AckValid), 64'd1);
        chk("ack_fcnt", AckFrameCount, c);
        chk("ack_minstret", AckMinstret, {32'h1, c[31:0]});
        chk("host_load", 64'(HostLoad), 64'(load));
        chk("drop_count", 64'(DropCount), 64'(exp_drop));
        chk("bad_frame_quiet", 64'(BadFrame), 64'd0);
    endtask

    task automatic pulse_sent(input int n);
        FrameSent = 1'b1;
        tick(n);
        FrameSent = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        RxData    = 32'd0;
        RxKeep    = 4'hF;
        RxValid   = 1'b0;
        RxLast    = 1'b0;
        FrameSent = 1'b0;
        tick(3);
        chk("rst_ready", 64'(RxReady), 64'd0);
        chk("rst_stall", 64'(ExternalStall), 64'd0);
        chk("rst_ackvalid", 64'(AckValid), 64'd0);
        chk("rst_drop", 64'(DropCount), 64'd0);
        chk("rst_load", 64'(HostLoad), 64'd0);
        chk("rst_timeout", 64'(Timeout), 64'd0);
        reset_n = 1'b1;
        tick(2);
        chk("ready", 64'(RxReady), 64'd1);

        // 1) three frames, three in-order acks
        pulse_sent(3);
        send_good(64'd0, 32'h10, 16'd0);
        tick();
        chk("ack_pulse_end", 64'(AckValid), 64'd0);
        send_good(64'd1, 32'h11, 16'd0);
        send_good(64'd2, 32'h12, 16'd0);
        chk("t1_outstanding", dut.outstanding, 64'd0);
        tick();
        chk("t1_stall", 64'(ExternalStall), 64'd0);

        // 2) eight unacked frames raise the stall one cycle later; skipping ack drops 7
        pulse_sent(8);
        chk("t2_stall_early", 64'(ExternalStall), 64'd0);
        tick();
        chk("t2_stall", 64'(ExternalStall), 64'd1);
        send_good(64'd10, 32'h0, 16'd7);
        tick();
        chk("t2_stall_clear", 64'(ExternalStall), 64'd0);

        // 3) host load above threshold stalls, low load releases
        pulse_sent(2);
        send_good(64'd11, 32'hD000_0000, 16'd7);
        tick();
        chk("t3_load_stall", 64'(ExternalStall), 64'd1);
        send_good(64'd12, 32'h1, 16'd7);
        tick();
        chk("t3_load_clear", 64'(ExternalStall), 64'd0);

        // 4) malformed frames, then stale and bogus counts
        send_frame(64'd13, 32'h0, 16'h0800, 8);
        chk("bad_type", 64'(BadFrame), 64'd1);
        send_frame(64'd13, 32'h0, RVVI_ETH_TYPE, 5);
        chk("bad_short", 64'(BadFrame), 64'd1);
        send_frame(64'd13, 32'h0, RVVI_ETH_TYPE, 9);
        chk("bad_long", 64'(BadFrame), 64'd1);
        tick();
        chk("bad_pulse_end", 64'(BadFrame), 64'd0);
        pulse_sent(3);
        send_frame(64'd0, 32'h0, RVVI_ETH_TYPE, 8);
        tick();
        chk("bad_stale", 64'(BadFrame), 64'd1);
        chk("stale_no_ack", 64'(AckValid), 64'd0);
        send_frame(64'd16, 32'h0, RVVI_ETH_TYPE, 8);
        tick();
        chk("bad_bogus", 64'(BadFrame), 64'd1);
        chk("bad_drop_kept", 64'(DropCount), 64'd7);
        send_good(64'd13, 32'h20, 16'd7);

        // 5) two frames left unacked: timeout 50 cycles after the last good ack
        tick(49);
        chk("t5_no_early_timeout", 64'(Timeout), 64'd0);
        tick();
        chk("t5_timeout", 64'(Timeout), 64'd1);
        chk("t5_drop", 64'(DropCount), 64'd9);
        chk("t5_load_clear", 64'(HostLoad), 64'd0);
        tick();
        chk("t5_timeout_pulse", 64'(Timeout), 64'd0);
        chk("t5_stall", 64'(ExternalStall), 64'd0);
        chk("t5_outstanding", dut.outstanding, 64'd0);

        // 6) FrameSent coincident with CHECK, then reset mid-frame
        pulse_sent(2);
        send_frame(64'd17, 32'h30, RVVI_ETH_TYPE, 8);
        FrameSent = 1'b1;
        tick();
        FrameSent = 1'b0;
        chk("t6_ack", 64'(AckValid), 64'd1);
        chk("t6_drop", 64'(DropCount), 64'd10);
        chk("t6_outstanding", dut.outstanding, 64'd1);
        for (int i = 0; i < 5; i++) begin
            RxData  = 32'hBEEF_0000 + 32'(i);
            RxValid = 1'b1;
            RxLast  = 1'b0;
            tick();
        end
        reset_n = 1'b0;
        RxValid = 1'b0;
        tick();
        chk("t6_rst_ready", 64'(RxReady), 64'd0);
        chk("t6_rst_drop", 64'(DropCount), 64'd0);
        chk("t6_rst_fcnt", AckFrameCount, 64'd0);
        chk("t6_rst_load", 64'(HostLoad), 64'd0);
        chk("t6_rst_state", 64'(dut.u_parser.state_q), 64'(StIdle));
        reset_n = 1'b1;
        tick(2);
        chk("t6_ready", 64'(RxReady), 64'd1);
        pulse_sent(1);
        send_good(64'd0, 32'h40, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
